vend_ctrl_multi: RTL and testbench

Parametrised multi-product vending controller: accepts nickel/dime/quarter coin pulses into a bounded credit register, tracks per-product stock, vends one product per transaction through a request/acknowledge handshake with the dispenser, then pays change as a train of nickel pulses. It sits between the debounced front-panel inputs (coin sensors, selection switches, cancel) and the dispenser and display drivers. It generalises the fixed four-product, 35c controller with configurable product count, prices, credit ceiling and stock.

---
 rtl/vend_ctrl_multi_if.sv | 36 +++
 rtl/vend_ctrl_multi.sv | 187 ++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_multi_if.sv
// rtl/vend_ctrl_multi_if.sv - front-panel / dispenser / display bus of the vending controller
// Ports (signals):
//   coin[2:0], sel[N_PROD-1:0], cancel, restock, vend_ack   panel/dispenser -> controller
//   vend[N_PROD-1:0], change_nickel, coin_reject, denied,
//   credit[CW-1:0], price_disp[CW-1:0], sold_out[N_PROD-1:0],
//   busy                                                    controller -> dispenser/display
// Modports: master = panel/dispenser side, slave = controller side.
`timescale 1ns/1ps
interface vend_ctrl_multi_if #(
  parameter int N_PROD = 4,
  parameter int CW     = 4
);
  logic [2:0]        coin;
  logic [N_PROD-1:0] sel;
  logic              cancel;
  logic              restock;
  logic              vend_ack;
  logic [N_PROD-1:0] vend;
  logic              change_nickel;
  logic              coin_reject;
  logic              denied;
  logic [CW-1:0]     credit;
  logic [CW-1:0]     price_disp;
  logic [N_PROD-1:0] sold_out;
  logic              busy;

  modport master (
    output coin, sel, cancel, restock, vend_ack,
    input  vend, change_nickel, coin_reject, denied, credit, price_disp, sold_out, busy
  );

  modport slave (
    input  coin, sel, cancel, restock, vend_ack,
    output vend, change_nickel, coin_reject, denied, credit, price_disp, sold_out, busy
  );
endinterface

// File: rtl/vend_ctrl_multi.sv
// rtl/vend_ctrl_multi.sv - parametrised multi-product vending controller
// Ports:
//   clk    in   system clock, rising edge
//   clr_n  in   asynchronous active-low reset
//   bus    vend_ctrl_multi_if.slave
//            in : coin (5c/10c/25c pulses), sel (lowest index wins), cancel, restock, vend_ack
//            out: vend (one-hot, held until ack), change_nickel, coin_reject, denied,
//                 credit, price_disp, sold_out, busy
`timescale 1ns/1ps
module vend_ctrl_multi #(
  parameter int                   N_PROD     = 4,
  parameter int                   CW         = 4,
  parameter int                   CREDIT_MAX = 7,
  parameter logic [N_PROD*CW-1:0] PRICES     = {4'd6, 4'd5, 4'd4, 4'd3},
  parameter int                   SW         = 4,
  parameter int                   STOCK_INIT = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  vend_ctrl_multi_if.slave bus
);
  localparam int IW = (N_PROD > 1) ? $clog2(N_PROD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_VEND, S_CHANGE} state_t;

  state_t                     r_state,       w_state_nxt;
  logic [CW-1:0]              r_credit,      w_credit_nxt;
  logic [N_PROD-1:0][SW-1:0]  r_stock,       w_stock_nxt;
  logic [N_PROD-1:0]          r_vend,        w_vend_nxt;
  logic [CW-1:0]              r_price,       w_price_nxt;
  logic                       r_change,      w_change_nxt;
  logic                       r_reject,      w_reject_nxt;
  logic                       r_denied,      w_denied_nxt;
  logic                       r_busy,        w_busy_nxt;

  logic                       w_sel_any;
  logic [IW-1:0]              w_sel_idx;
  logic [CW-1:0]              w_sel_price;
  logic                       w_coin_one;
  logic [CW:0]                w_coin_val;
  logic [CW:0]                w_coin_sum;
  logic                       w_coin_take;
  logic [N_PROD-1:0]          w_sold_out;

  // Lowest set selection bit wins: scan downwards so the last hit is the lowest.
  always_comb begin
    w_sel_idx = '0;
    for (int i = N_PROD - 1; i >= 0; i--) begin
      if (bus.sel[i]) w_sel_idx = IW'(i);
    end
  end

  assign w_sel_any   = |bus.sel;
  assign w_sel_price = PRICES[w_sel_idx*CW +: CW];

  assign w_coin_one = (bus.coin == 3'b001) || (bus.coin == 3'b010) || (bus.coin == 3'b100);

  always_comb begin
    w_coin_val = '0;
    case (bus.coin)
      3'b001:  w_coin_val = (CW+1)'(1);
      3'b010:  w_coin_val = (CW+1)'(2);
      3'b100:  w_coin_val = (CW+1)'(5);
      default: w_coin_val = '0;
    endcase
  end

  // One extra bit so an overflowing sum is still compared correctly against the ceiling.
  assign w_coin_sum = {1'b0, r_credit} + w_coin_val;

  always_comb begin
    w_sold_out = '0;
    for (int i = 0; i < N_PROD; i++) begin
      w_sold_out[i] = (r_stock[i] == '0);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_stock_nxt  = r_stock;
    w_vend_nxt   = r_vend;
    w_price_nxt  = r_price;
    w_change_nxt = 1'b0;
    w_denied_nxt = 1'b0;
    w_coin_take  = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.cancel) begin
          // Entering CHANGE pays the first nickel on the same edge.
          if (r_credit != '0) begin
            w_state_nxt  = S_CHANGE;
            w_credit_nxt = r_credit - CW'(1);
            w_change_nxt = 1'b1;
          end
        end else if (w_sel_any) begin
          w_price_nxt = w_sel_price;
          if ((r_credit >= w_sel_price) && (r_stock[w_sel_idx] != '0)) begin
            w_credit_nxt            = r_credit - w_sel_price;
            w_stock_nxt[w_sel_idx]  = r_stock[w_sel_idx] - SW'(1);
            w_vend_nxt              = '0;
            w_vend_nxt[w_sel_idx]   = 1'b1;
            w_state_nxt             = S_VEND;
          end else begin
            w_denied_nxt = 1'b1;
          end
        end else if (w_coin_one && (w_coin_sum <= (CW+1)'(CREDIT_MAX))) begin
          w_credit_nxt = w_coin_sum[CW-1:0];
          w_coin_take  = 1'b1;
        end

        // Restock never collides with a stock decrement: it needs sel idle.
        if (bus.restock && !w_sel_any) begin
          for (int i = 0; i < N_PROD; i++) begin
            w_stock_nxt[i] = SW'(STOCK_INIT);
          end
        end
      end

      S_VEND: begin
        if (bus.vend_ack) begin
          w_vend_nxt = '0;
          if (r_credit != '0) begin
            w_state_nxt  = S_CHANGE;
            w_credit_nxt = r_credit - CW'(1);
            w_change_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_CHANGE: begin
        if (r_credit != '0) begin
          w_credit_nxt = r_credit - CW'(1);
          w_change_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Every coin pulse that was not credited goes back out the return chute.
    w_reject_nxt = (bus.coin != 3'b000) && !w_coin_take;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      for (int i = 0; i < N_PROD; i++) begin
        r_stock[i] <= SW'(STOCK_INIT);
      end
      r_vend   <= '0;
      r_price  <= '0;
      r_change <= 1'b0;
      r_reject <= 1'b0;
      r_denied <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_stock  <= w_stock_nxt;
      r_vend   <= w_vend_nxt;
      r_price  <= w_price_nxt;
      r_change <= w_change_nxt;
      r_reject <= w_reject_nxt;
      r_denied <= w_denied_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign bus.vend          = r_vend;
  assign bus.change_nickel = r_change;
  assign bus.coin_reject   = r_reject;
  assign bus.denied        = r_denied;
  assign bus.credit        = r_credit;
  assign bus.price_disp    = r_price;
  assign bus.sold_out      = w_sold_out;
  assign bus.busy          = r_busy;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb/tb_vend_ctrl_multi.sv - self-checking bench for vend_ctrl_multi
`timescale 1ns/1ps
module tb_vend_ctrl_multi;
  localparam int N = 4;
  localparam int CMAX = 7;
  localparam int SINIT = 2;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_fail;
  int   price_tab[N] = '{3, 4, 5, 6};

  vend_ctrl_multi_if #(.N_PROD(N), .CW(4)) bus ();

  vend_ctrl_multi dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: credit in units, stock per product, and an operating phase.
  int m_credit, m_price, m_phase, m_vend_idx, m_left;
  int m_stock[N];
  bit e_reject, e_denied, e_nickel;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.coin = 3'b000; bus.sel = '0; bus.cancel = 1'b0; bus.restock = 1'b0; bus.vend_ack = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    clr_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1'b1;
  endtask

  task automatic model_reset();
    m_credit = 0; m_price = 0; m_phase = 0; m_vend_idx = -1; m_left = 0;
    for (int k = 0; k < N; k++) m_stock[k] = SINIT;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  // phase 0 = waiting for customer, 1 = product being dispensed, 2 = paying back change.
  task automatic model_step();
    int ncoins, val, idx;
    bit sel_any;
    ncoins  = $countones(bus.coin);
    val     = bus.coin[0] ? 1 : (bus.coin[1] ? 2 : 5);
    sel_any = (bus.sel != 0);
    e_reject = 0; e_denied = 0; e_nickel = 0;
    if (ncoins > 0)
      e_reject = (m_phase != 0) || bus.cancel || sel_any || (ncoins > 1) || (m_credit + val > CMAX);
    if (m_phase == 0) begin
      if (bus.cancel) begin
        if (m_credit > 0) begin m_left = m_credit; m_phase = 2; end
      end else if (sel_any) begin
        idx = 0;
        for (int k = N - 1; k >= 0; k--) if (bus.sel[k]) idx = k;
        m_price = price_tab[idx];
        if (m_credit >= m_price && m_stock[idx] > 0) begin
          m_credit -= m_price; m_stock[idx] -= 1; m_vend_idx = idx; m_phase = 1;
        end else e_denied = 1;
      end else if (ncoins == 1 && !e_reject) begin
        m_credit += val;
      end
      if (!sel_any && bus.restock) for (int k = 0; k < N; k++) m_stock[k] = SINIT;
    end else if (m_phase == 1) begin
      if (bus.vend_ack) begin
        m_vend_idx = -1;
        if (m_credit > 0) begin m_left = m_credit; m_phase = 2; end
        else m_phase = 0;
      end
    end
    if (m_phase == 2) begin
      if (m_left > 0) begin e_nickel = 1; m_left -= 1; m_credit -= 1; end
      else m_phase = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.credit !== 4'd0) begin n_fail++; $display("FAIL reset_credit: got %0d expected 0", bus.credit); end
    n_checks++; if (bus.price_disp !== 4'd0) begin n_fail++; $display("FAIL reset_price: got %0d expected 0", bus.price_disp); end
    n_checks++; if (bus.sold_out !== 4'b0000 || bus.busy !== 1'b0 || bus.vend !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs: got sold_out=%b busy=%b vend=%b expected 0000/0/0000", bus.sold_out, bus.busy, bus.vend); end
    bus.coin = 3'b100; tick(); bus.coin = 3'b000;
    bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
    n_checks++; if (bus.change_nickel !== 1'b1 || bus.credit !== 4'd4) begin
      n_fail++; $display("FAIL reset_prechange: got nickel=%b credit=%0d expected 1/4", bus.change_nickel, bus.credit); end
    clr_n = 1'b0;
    #1;
    n_checks++; if (bus.credit !== 4'd0 || bus.change_nickel !== 1'b0 || bus.vend !== 4'b0000 || bus.sold_out !== 4'b0000 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_midchange: got credit=%0d nickel=%b vend=%b sold_out=%b busy=%b expected 0/0/0000/0000/0",
                         bus.credit, bus.change_nickel, bus.vend, bus.sold_out, bus.busy); end
    clr_n = 1'b1;
    bus.coin = 3'b100; tick(); bus.coin = 3'b000;
    n_checks++; if (bus.credit !== 4'd5) begin n_fail++; $display("FAIL reset_after_coin: got %0d expected 5", bus.credit); end
  endtask

  task automatic test_credit();
    do_reset();
    bus.coin = 3'b100; tick();
    bus.coin = 3'b010; tick(); bus.coin = 3'b000;
    n_checks++; if (bus.credit !== 4'd7) begin n_fail++; $display("FAIL credit_sum: got %0d expected 7", bus.credit); end
    bus.coin = 3'b001; tick(); bus.coin = 3'b000;
    n_checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 4'd7) begin
      n_fail++; $display("FAIL credit_ceiling: got reject=%b credit=%0d expected 1/7", bus.coin_reject, bus.credit); end
    tick();
    n_checks++; if (bus.coin_reject !== 1'b0) begin n_fail++; $display("FAIL reject_pulse_width: got %b expected 0", bus.coin_reject); end
    bus.coin = 3'b011; tick(); bus.coin = 3'b000;
    n_checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 4'd7) begin
      n_fail++; $display("FAIL credit_multicoin: got reject=%b credit=%0d expected 1/7", bus.coin_reject, bus.credit); end
  endtask

  task automatic test_purchase();
    int cnt;
    bus.sel = 4'b0001; tick(); bus.sel = '0;
    n_checks++; if (bus.vend !== 4'b0001 || bus.credit !== 4'd4 || bus.price_disp !== 4'd3 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL purchase_vend: got vend=%b credit=%0d price=%0d busy=%b expected 0001/4/3/1",
                         bus.vend, bus.credit, bus.price_disp, bus.busy); end
    tick(); tick();
    n_checks++; if (bus.vend !== 4'b0001) begin n_fail++; $display("FAIL purchase_vend_held: got %b expected 0001", bus.vend); end
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
    n_checks++; if (bus.vend !== 4'b0000) begin n_fail++; $display("FAIL purchase_vend_clear: got %b expected 0000", bus.vend); end
    cnt = bus.change_nickel ? 1 : 0;
    for (int k = 0; k < 6; k++) begin tick(); if (bus.change_nickel) cnt++; end
    n_checks++; if (cnt != 4) begin n_fail++; $display("FAIL purchase_change_count: got %0d expected 4", cnt); end
    n_checks++; if (bus.credit !== 4'd0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL purchase_end: got credit=%0d busy=%b expected 0/0", bus.credit, bus.busy); end
  endtask

  task automatic test_denied();
    int cnt;
    bit vend_seen;
    do_reset();
    bus.coin = 3'b010; tick(); bus.coin = 3'b000;
    bus.sel = 4'b0110; tick(); bus.sel = '0;
    n_checks++; if (bus.denied !== 1'b1 || bus.price_disp !== 4'd4 || bus.credit !== 4'd2 || bus.vend !== 4'b0000) begin
      n_fail++; $display("FAIL denied_low_credit: got denied=%b price=%0d credit=%0d vend=%b expected 1/4/2/0000",
                         bus.denied, bus.price_disp, bus.credit, bus.vend); end
    tick();
    n_checks++; if (bus.denied !== 1'b0) begin n_fail++; $display("FAIL denied_pulse_width: got %b expected 0", bus.denied); end
    bus.cancel = 1'b1; bus.sel = 4'b0001; bus.coin = 3'b001; tick(); clear_inputs();
    n_checks++; if (bus.coin_reject !== 1'b1) begin n_fail++; $display("FAIL cancel_coin_reject: got %b expected 1", bus.coin_reject); end
    cnt = bus.change_nickel ? 1 : 0;
    vend_seen = (bus.vend != 0);
    for (int k = 0; k < 4; k++) begin tick(); if (bus.change_nickel) cnt++; if (bus.vend != 0) vend_seen = 1; end
    n_checks++; if (cnt != 2 || vend_seen) begin
      n_fail++; $display("FAIL cancel_priority: got nickels=%0d vend_seen=%0d expected 2/0", cnt, vend_seen); end
  endtask

  task automatic test_stock();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      bus.coin = 3'b100; tick(); bus.coin = 3'b001; tick(); bus.coin = 3'b000;
      bus.sel = 4'b1000; tick(); bus.sel = '0;
      n_checks++; if (bus.vend !== 4'b1000 || bus.credit !== 4'd0) begin
        n_fail++; $display("FAIL stock_buy%0d: got vend=%b credit=%0d expected 1000/0", k, bus.vend, bus.credit); end
      bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
      n_checks++; if (bus.change_nickel !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++; $display("FAIL stock_exact_price%0d: got nickel=%b busy=%b expected 0/0", k, bus.change_nickel, bus.busy); end
    end
    n_checks++; if (bus.sold_out !== 4'b1000) begin n_fail++; $display("FAIL stock_sold_out: got %b expected 1000", bus.sold_out); end
    bus.coin = 3'b100; tick(); bus.coin = 3'b001; tick(); bus.coin = 3'b000;
    bus.sel = 4'b1000; tick(); bus.sel = '0;
    n_checks++; if (bus.denied !== 1'b1 || bus.vend !== 4'b0000 || bus.credit !== 4'd6) begin
      n_fail++; $display("FAIL stock_empty_denied: got denied=%b vend=%b credit=%0d expected 1/0000/6", bus.denied, bus.vend, bus.credit); end
    bus.restock = 1'b1; tick(); bus.restock = 1'b0;
    n_checks++; if (bus.sold_out !== 4'b0000) begin n_fail++; $display("FAIL restock: got %b expected 0000", bus.sold_out); end
    bus.sel = 4'b1000; tick(); bus.sel = '0;
    n_checks++; if (bus.vend !== 4'b1000 || bus.credit !== 4'd0) begin
      n_fail++; $display("FAIL restock_buy: got vend=%b credit=%0d expected 1000/0", bus.vend, bus.credit); end
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
  endtask

  task automatic test_ignored();
    do_reset();
    bus.coin = 3'b100; tick(); bus.coin = 3'b000;
    bus.sel = 4'b0001; tick(); bus.sel = '0;
    bus.coin = 3'b100; tick(); bus.coin = 3'b000;
    n_checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 4'd2 || bus.vend !== 4'b0001) begin
      n_fail++; $display("FAIL coin_in_vend: got reject=%b credit=%0d vend=%b expected 1/2/0001", bus.coin_reject, bus.credit, bus.vend); end
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
    tick(); tick();
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
    n_checks++; if (bus.vend !== 4'b0000 || bus.busy !== 1'b0 || bus.credit !== 4'd0 || bus.change_nickel !== 1'b0) begin
      n_fail++; $display("FAIL ack_in_idle: got vend=%b busy=%b credit=%0d nickel=%b expected 0000/0/0/0",
                         bus.vend, bus.busy, bus.credit, bus.change_nickel); end
    bus.coin = 3'b100; tick(); bus.coin = 3'b010; tick(); bus.coin = 3'b000;
    bus.sel = 4'b0001; bus.restock = 1'b1; tick(); clear_inputs();
    n_checks++; if (bus.vend !== 4'b0001 || bus.sold_out !== 4'b0001 || bus.credit !== 4'd4) begin
      n_fail++; $display("FAIL restock_with_sel: got vend=%b sold_out=%b credit=%0d expected 0001/0001/4", bus.vend, bus.sold_out, bus.credit); end
    bus.vend_ack = 1'b1; tick(); bus.vend_ack = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_random();
    logic [3:0] e_vend;
    do_reset();
    model_reset();
    for (int c = 0; c < 800; c++) begin
      bus.coin     = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      bus.sel      = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      bus.cancel   = ($urandom_range(0, 24) == 0);
      bus.restock  = ($urandom_range(0, 39) == 0);
      bus.vend_ack = ($urandom_range(0, 2) == 0);
      model_step();
      tick();
      e_vend = (m_vend_idx >= 0) ? 4'(1 << m_vend_idx) : 4'b0000;
      n_checks++; if (bus.credit !== 4'(m_credit)) begin n_fail++; $display("FAIL rnd_credit cyc %0d: got %0d expected %0d", c, bus.credit, m_credit); end
      n_checks++; if (bus.vend !== e_vend) begin n_fail++; $display("FAIL rnd_vend cyc %0d: got %b expected %b", c, bus.vend, e_vend); end
      n_checks++; if (bus.change_nickel !== e_nickel) begin n_fail++; $display("FAIL rnd_nickel cyc %0d: got %b expected %b", c, bus.change_nickel, e_nickel); end
      n_checks++; if (bus.coin_reject !== e_reject) begin n_fail++; $display("FAIL rnd_reject cyc %0d: got %b expected %b", c, bus.coin_reject, e_reject); end
      n_checks++; if (bus.denied !== e_denied) begin n_fail++; $display("FAIL rnd_denied cyc %0d: got %b expected %b", c, bus.denied, e_denied); end
      n_checks++; if (bus.busy !== (m_phase != 0)) begin n_fail++; $display("FAIL rnd_busy cyc %0d: got %b expected %b", c, bus.busy, (m_phase != 0)); end
      n_checks++; if (bus.price_disp !== 4'(m_price)) begin n_fail++; $display("FAIL rnd_price cyc %0d: got %0d expected %0d", c, bus.price_disp, m_price); end
      for (int k = 0; k < N; k++) begin
        n_checks++; if (bus.sold_out[k] !== (m_stock[k] == 0)) begin
          n_fail++; $display("FAIL rnd_sold_out[%0d] cyc %0d: got %b expected %b", k, c, bus.sold_out[k], (m_stock[k] == 0)); end
      end
    end
    clear_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    clr_n    = 1'b0;
    clear_inputs();
    test_reset();
    test_credit();
    test_purchase();
    test_denied();
    test_stock();
    test_ignored();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
